// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared widths, ids, child field slices and FSM states for the Huffman decoder
// Ports: none (package).
package huffman_pkg;

  localparam int SYM_W     = 3;   // 8 leaf symbols
  localparam int ID_W      = 4;   // 0-7 leaves, 8-14 internal nodes 1-7, 15 invalid
  localparam int NODE_W    = 13;  // full descriptor width from generate_tree
  localparam int MAX_DEPTH = 7;   // longest legal code, in bits
  localparam int DEPTH_W   = 3;
  localparam int N_NODES   = 7;
  localparam int CHILD_W   = 2 * ID_W;  // only the child-id part of a descriptor is kept

  localparam logic [ID_W-1:0] ROOT_ID    = 4'd14;
  localparam logic [ID_W-1:0] LEAF_MAX   = 4'd7;
  localparam logic [ID_W-1:0] INVALID_ID = 4'd15;

  // Child id fields inside a node descriptor.
  localparam int LEFT_MSB  = 7;
  localparam int LEFT_LSB  = 4;
  localparam int RIGHT_MSB = 3;
  localparam int RIGHT_LSB = 0;

  typedef enum logic [1:0] {
    NO_TREE,
    WALK,
    HOLD,
    ERR
  } state_t;

  function automatic logic is_leaf(input logic [ID_W-1:0] id);
    return id <= LEAF_MAX;
  endfunction

endpackage

// File: rtl/huffman_decode_if.sv
// rtl/huffman_decode_if.sv - code-bit input stream and symbol output stream of the decoder
// Signals: bit_in/bit_valid/bit_ready (code bits, 0 = left, 1 = right),
//          sym_out/sym_valid/sym_ready (decoded symbols).
// Modports: master = bit source + symbol sink, slave = decoder.
interface huffman_decode_if;
  import huffman_pkg::*;

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             sym_ready;

  modport master (
    output bit_in, bit_valid, sym_ready,
    input  bit_ready, sym_out, sym_valid
  );

  modport slave (
    input  bit_in, bit_valid, sym_ready,
    output bit_ready, sym_out, sym_valid
  );

endinterface

// File: rtl/huffman_node_mux.sv
// rtl/huffman_node_mux.sv - picks the left or right child id of the current node
// Ports: nodes (7 stored child-id pairs, index 0 = node 1 = id 8), cur (current node id),
//        bit_in (0 = left, 1 = right), child (selected child id).
module huffman_node_mux
  import huffman_pkg::*;
(
  input  logic [N_NODES-1:0][CHILD_W-1:0] nodes,
  input  logic [ID_W-1:0]                 cur,
  input  logic                            bit_in,
  output logic [ID_W-1:0]                 child
);

  logic [CHILD_W-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (cur == 4'(i + 8)) sel = nodes[i];
    end
    child = bit_in ? sel[RIGHT_MSB:RIGHT_LSB] : sel[LEFT_MSB:LEFT_LSB];
  end

endmodule

// File: rtl/huffman_decode.sv
// rtl/huffman_decode.sv - serial Huffman tree walker, one code bit per accepted bit
// Ports: CLK, nRST (async active-low), tree_load (loads info_node_1..7, restarts the walk),
//        info_node_1..7 (node k = id k+7, [7:4] left child, [3:0] right child),
//        bus (huffman_decode_if.slave: bit stream in, symbol stream out),
//        dec_err (sticky: invalid child or code longer than MAX_DEPTH),
//        sym_count (only with HUFF_DECODE_STATS_EN: saturating count of consumed symbols).
module huffman_decode
  import huffman_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              tree_load,
  input  logic [NODE_W-1:0] info_node_1,
  input  logic [NODE_W-1:0] info_node_2,
  input  logic [NODE_W-1:0] info_node_3,
  input  logic [NODE_W-1:0] info_node_4,
  input  logic [NODE_W-1:0] info_node_5,
  input  logic [NODE_W-1:0] info_node_6,
  input  logic [NODE_W-1:0] info_node_7,
  huffman_decode_if.slave   bus,
  output logic              dec_err
`ifdef HUFF_DECODE_STATS_EN
  ,
  output logic [15:0]       sym_count
`endif
);

  state_t                          state;
  logic [N_NODES-1:0][CHILD_W-1:0] nodes;
  logic [N_NODES-1:0][CHILD_W-1:0] load_nodes;
  logic [ID_W-1:0]                 cur;
  logic [ID_W-1:0]                 child;
  logic [DEPTH_W-1:0]              depth;
  logic [SYM_W-1:0]                sym_out_q;
  logic                            sym_valid_q;
  logic                            bit_ready;
  logic                            accept;
  logic                            descend_ok;

  // Descriptor bits above the child ids belong to the tree builder, not to us.
  logic unused_hi;
  assign unused_hi = ^{info_node_1[NODE_W-1:CHILD_W], info_node_2[NODE_W-1:CHILD_W],
                       info_node_3[NODE_W-1:CHILD_W], info_node_4[NODE_W-1:CHILD_W],
                       info_node_5[NODE_W-1:CHILD_W], info_node_6[NODE_W-1:CHILD_W],
                       info_node_7[NODE_W-1:CHILD_W]};

  assign load_nodes = {info_node_7[LEFT_MSB:RIGHT_LSB], info_node_6[LEFT_MSB:RIGHT_LSB],
                       info_node_5[LEFT_MSB:RIGHT_LSB], info_node_4[LEFT_MSB:RIGHT_LSB],
                       info_node_3[LEFT_MSB:RIGHT_LSB], info_node_2[LEFT_MSB:RIGHT_LSB],
                       info_node_1[LEFT_MSB:RIGHT_LSB]};

  huffman_node_mux u_node_mux (
    .nodes  (nodes),
    .cur    (cur),
    .bit_in (bus.bit_in),
    .child  (child)
  );

  // In HOLD a bit may only enter when the pending symbol leaves in the same cycle.
  always_comb begin
    case (state)
      WALK:    bit_ready = 1'b1;
      HOLD:    bit_ready = bus.sym_ready;
      default: bit_ready = 1'b0;
    endcase
  end

  assign accept     = bus.bit_valid && bit_ready;
  // Descending is legal only if the extra level still leaves room for a leaf bit.
  assign descend_ok = (child != INVALID_ID) && (({1'b0, depth} + 4'd1) < 4'(MAX_DEPTH));

  assign bus.bit_ready = bit_ready;
  assign bus.sym_out   = sym_out_q;
  assign bus.sym_valid = sym_valid_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= NO_TREE;
      nodes       <= '0;
      cur         <= ROOT_ID;
      depth       <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      dec_err     <= 1'b0;
    end else if (tree_load) begin
      // Overrides any bit accepted this cycle; a partial code is dropped.
      nodes       <= load_nodes;
      cur         <= ROOT_ID;
      depth       <= '0;
      sym_valid_q <= 1'b0;
      dec_err     <= 1'b0;
      state       <= WALK;
    end else begin
      case (state)
        WALK, HOLD: begin
          if (accept) begin
            if (is_leaf(child)) begin
              sym_out_q   <= child[SYM_W-1:0];
              sym_valid_q <= 1'b1;
              cur         <= ROOT_ID;
              depth       <= '0;
              state       <= HOLD;
            end else if (descend_ok) begin
              sym_valid_q <= 1'b0;
              cur         <= child;
              depth       <= depth + 3'd1;
              state       <= WALK;
            end else begin
              sym_valid_q <= 1'b0;
              dec_err     <= 1'b1;
              state       <= ERR;
            end
          end else if (state == HOLD && bus.sym_ready) begin
            sym_valid_q <= 1'b0;
            state       <= WALK;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HUFF_DECODE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sym_count <= '0;
    end else if (tree_load) begin
      sym_count <= '0;
    end else if (sym_valid_q && bus.sym_ready && sym_count != 16'hFFFF) begin
      sym_count <= sym_count + 16'd1;
    end
  end
`endif

endmodule
